// File: rtl/spram8_128k_if.sv
// iBus8 byte bus between the ForthSuper core (master) and its 128 KiB memory (slave).
interface spram8_128k_if #(
    parameter int ASZ = 17,
    parameter int DSZ = 8
);
    logic [ASZ-1:0] ai;
    logic [DSZ-1:0] vi;
    logic [DSZ-1:0] vo;
    logic           we;

    modport master (output ai, output vi, output we, input vo);
    modport slave  (input ai, input vi, input we, output vo);
endinterface

// File: rtl/spram8_128k.sv
// 128 KiB byte-addressable RAM: four 16K x 16 banks behind an 8-bit bus, 1-cycle registered read.
// Optional macro SPRAM8_WRITE_THRU_EN: written byte is also presented on vo after a write edge.
module spram8_128k #(
    parameter int ASZ = 17,
    parameter int DSZ = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    spram8_128k_if.slave  b8
);
    localparam int BANKS = 4;
    localparam int WSZ   = ASZ - 3;
    localparam int DEPTH = 1 << WSZ;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_READ,
        SRC_WRITE
    } src_t;

    logic [1:0]     bank;
    logic [WSZ-1:0] waddr;
    logic           lane;
    logic [15:0]    rd_words [BANKS];

    src_t           src_q;
    logic [1:0]     bank_q;
    logic           lane_q;
    logic [DSZ-1:0] vo_mux;

    assign bank  = b8.ai[ASZ-1 -: 2];
    assign waddr = b8.ai[ASZ-3:1];
    assign lane  = b8.ai[0];

    // Each bank sees only its own write strobe; its read word stays put until that bank is read again.
    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        logic [15:0] mem [DEPTH];
        logic [15:0] q;
        logic        sel;
        logic [1:0]  mask;

        assign sel  = rst_n && (bank == 2'(g));
        assign mask = lane ? 2'b10 : 2'b01;

        always_ff @(posedge clk) begin
            if (sel && b8.we) begin
                if (mask[0]) mem[waddr][7:0]  <= b8.vi;
                if (mask[1]) mem[waddr][15:8] <= b8.vi;
            end else if (sel) begin
                q <= mem[waddr];
            end
        end

        assign rd_words[g] = q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= SRC_NONE;
            bank_q <= 2'b00;
            lane_q <= 1'b0;
        end else if (!b8.we) begin
            src_q  <= SRC_READ;
            bank_q <= bank;
            lane_q <= lane;
        end
`ifdef SPRAM8_WRITE_THRU_EN
        else begin
            src_q  <= SRC_WRITE;
        end
`endif
    end

`ifdef SPRAM8_WRITE_THRU_EN
    logic [DSZ-1:0] wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_q <= '0;
        end else if (b8.we) begin
            wdata_q <= b8.vi;
        end
    end
`endif

    // SRC_NONE covers the post-reset state so vo reads zero until the first access.
    always_comb begin
        vo_mux = '0;
        case (src_q)
            SRC_READ: vo_mux = lane_q ? rd_words[bank_q][15:8] : rd_words[bank_q][7:0];
`ifdef SPRAM8_WRITE_THRU_EN
            SRC_WRITE: vo_mux = wdata_q;
`endif
            default: vo_mux = '0;
        endcase
    end

    assign b8.vo = vo_mux;
endmodule

// File: tb/tb_spram8_128k.sv
// Scoreboard bench for spram8_128k: directed address patterns plus random traffic against a byte-array model.
module tb_spram8_128k;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spram8_128k_if bus ();

    spram8_128k dut (
        .clk   (clk),
        .rst_n (rst_n),
        .b8    (bus.slave)
    );

    typedef struct {
        logic        known;
        logic [7:0]  val;
        logic [16:0] addr;
        logic        is_write;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_mem [int];
    logic       vo_known = 1'b1;
    logic [7:0] vo_model = 8'h00;
    int         assertions = 0;
    int         failures = 0;
    logic [16:0] pool [16];

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
        assertions++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: vo=%02h required=%02h", name, actual, required);
        end
    endtask

    // One bus access per call; the expected vo after the edge is computed from the byte model.
    task automatic applyStimulus(input logic w, input logic [16:0] a, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        bus.we = w;
        bus.ai = a;
        bus.vi = d;
        if (w) begin
            model_mem[int'(a)] = d;
`ifdef SPRAM8_WRITE_THRU_EN
            vo_known = 1'b1;
            vo_model = d;
`endif
        end else if (model_mem.exists(int'(a))) begin
            vo_known = 1'b1;
            vo_model = model_mem[int'(a)];
        end else begin
            vo_known = 1'b0;
        end
        e.known    = vo_known;
        e.val      = vo_model;
        e.addr     = a;
        e.is_write = w;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin : monitor
        exp_t m;
        #1;
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            if (m.known)
                checkOutput($sformatf("%s@%05h", m.is_write ? "wr" : "rd", m.addr), bus.vo, m.val);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: run did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v;
        bus.we = 1'b0;
        bus.ai = '0;
        bus.vi = '0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("reset_vo", bus.vo, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        vo_known = 1'b1;
        vo_model = 8'h00;

        $display("[TB] byte order");
        for (int i = 0; i <= 16; i++) applyStimulus(1'b1, 17'(i), 8'(i));
        for (int i = 0; i <= 20; i++) applyStimulus(1'b0, 17'(i), 8'h00);

        $display("[TB] lane isolation");
        applyStimulus(1'b1, 17'h00001, 8'hAA);
        applyStimulus(1'b1, 17'h00000, 8'h55);
        applyStimulus(1'b0, 17'h00000, 8'h00);
        applyStimulus(1'b0, 17'h00001, 8'h00);

        $display("[TB] bank decode");
        for (int i = 0; i <= 16; i++) begin
            v = (i < 8) ? (1 << i) : (255 >> (i - 8));
            applyStimulus(1'b1, 17'((1 << i) | (i & 3)), 8'(v));
        end
        for (int i = 0; i <= 16; i++) applyStimulus(1'b0, 17'((1 << i) | (i & 3)), 8'h00);

        $display("[TB] high addresses");
        for (int i = 0; i <= 16; i++) applyStimulus(1'b1, 17'(32'h1FFFF - i), 8'(i));
        applyStimulus(1'b0, 17'h1FFFF, 8'h00);
        applyStimulus(1'b0, 17'h1FFEF, 8'h00);
        for (int i = 0; i <= 16; i++) applyStimulus(1'b0, 17'(i), 8'h00);

        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 17'h00100, 8'h3C);
        applyStimulus(1'b0, 17'h00100, 8'h00);
        applyStimulus(1'b0, 17'h00000, 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkOutput("reset_midread", bus.vo, 8'h00);
        @(negedge clk);
        bus.we = 1'b1;
        bus.ai = 17'h00100;
        bus.vi = 8'hEE;
        @(posedge clk);
        #1 checkOutput("reset_hold", bus.vo, 8'h00);
        @(negedge clk);
        bus.we = 1'b0;
        rst_n = 1'b1;
        vo_known = 1'b1;
        vo_model = 8'h00;
        applyStimulus(1'b0, 17'h00100, 8'h00);

        $display("[TB] write cycle output");
        applyStimulus(1'b0, 17'h00000, 8'h00);
        applyStimulus(1'b1, 17'h00020, 8'h5A);
        applyStimulus(1'b0, 17'h00020, 8'h00);

        $display("[TB] random traffic");
        for (int i = 0; i < 16; i++) pool[i] = 17'($urandom_range(0, 32'h1FFFF));
        pool[1] = pool[0] ^ 17'h1;
        pool[3] = pool[2] ^ 17'h08000;
        pool[5] = pool[4] ^ 17'h10000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0)
                applyStimulus(1'b0, 17'($urandom_range(0, 32'h1FFFF)), 8'h00);
            else
                applyStimulus(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)], 8'($urandom_range(0, 255)));
        end

        repeat (3) @(posedge clk);
        #2;
        assertions++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: pending=%0d required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
